// File: rtl/one_pass_top.sv
// Single-pass convolution engine with its byte-addressed global buffer.
// One output word is produced every K+3 cycles: a bias read, K MAC cycles,
// one drain cycle for the last in-flight product, and one 32-bit write.

module one_pass_glb #(
  parameter int GLB_BYTES = 65536,
  parameter int AW        = $clog2(GLB_BYTES)
) (
  input  logic          clk,
  input  logic [AW-1:0] ra0,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] rwa,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [31:0]   wdata,
  output logic [7:0]    rd0,
  output logic [7:0]    rd1,
  output logic [31:0]   rword
);

  localparam logic [AW-1:0] ONE = AW'(1);

  logic [7:0] mem [GLB_BYTES];

  // Two byte read ports, one little-endian word view and one word write port.
  // NOTE: the storage array is deliberately left out of reset; it is preloaded
  // by the host and must survive an aborted pass.
  always_ff @(posedge clk) begin
    rd0   <= mem[ra0];
    rd1   <= mem[ra1];
    rword <= {mem[rwa + AW'(3)], mem[rwa + AW'(2)], mem[rwa + ONE], mem[rwa]};
    if (we) begin
      mem[wa]          <= wdata[7:0];
      mem[wa + ONE]    <= wdata[15:8];
      mem[wa + AW'(2)] <= wdata[23:16];
      mem[wa + AW'(3)] <= wdata[31:24];
    end
  end

endmodule

module one_pass_top #(
  parameter int GLB_BYTES = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] p,
  input  logic [3:0] t,
  input  logic [3:0] q,
  input  logic [3:0] r,
  input  logic [7:0] e,
  input  logic [3:0] STRIDE,
  input  logic [3:0] FILT_ROW,
  input  logic [3:0] FILT_COL,
  input  logic [7:0] IFMAP_COL,
  input  logic [7:0] OFMAP_COL,
  output logic       done
);

  localparam int AW = $clog2(GLB_BYTES);
  localparam logic [AW-1:0] ONE = AW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BIAS  = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state;

  // Configuration captured when a pass is launched.
  logic [3:0] cp, ct, cq, cr, cs, cfr, cfc;
  logic [7:0] ce, cic, coc;
  logic       skip;

  // Output position (m, y, x), linear output index, and MAC position (c, fr, fc).
  logic [AW-1:0] mc, yc, xc, oi;
  logic [AW-1:0] cc, frc, fcc, widx;
  logic [31:0]   acc;

  // Geometry derived from the captured configuration.
  logic [AW-1:0] m_tot, c_tot, h_tot, k_tot, f0, b0, o0;
  assign m_tot = AW'(cp) * AW'(ct);
  assign c_tot = AW'(cq) * AW'(cr);
  assign h_tot = AW'(cs) * (AW'(ce) - ONE) + AW'(cfc);
  assign k_tot = c_tot * AW'(cfr) * AW'(cfc);
  assign f0    = c_tot * h_tot * AW'(cic);
  assign b0    = f0 + m_tot * k_tot;
  assign o0    = b0 + (m_tot << 2);

  // GLB addresses for the current output / MAC position.
  logic [AW-1:0] ifm_addr, wgt_addr, bias_addr, out_addr;
  assign ifm_addr  = cc * h_tot * AW'(cic)
                   + (yc * AW'(cs) + frc) * AW'(cic)
                   + xc * AW'(cs) + fcc;
  assign wgt_addr  = f0 + mc * k_tot + widx;
  assign bias_addr = b0 + (mc << 2);
  assign out_addr  = o0 + (oi << 2);

  logic [7:0]  ifm_byte, wgt_byte;
  logic [31:0] bias_word;

  one_pass_glb #(.GLB_BYTES(GLB_BYTES), .AW(AW)) glb (
    .clk   (clk),
    .ra0   (ifm_addr),
    .ra1   (wgt_addr),
    .rwa   (bias_addr),
    .we    (state == WRITE),
    .wa    (out_addr),
    .wdata (acc),
    .rd0   (ifm_byte),
    .rd1   (wgt_byte),
    .rword (bias_word)
  );

  // Signed 8x8 product of the bytes read in the previous cycle, widened to 32.
  logic signed [15:0] ifm_ext, wgt_ext, prod;
  logic [31:0]        prod_ext;
  assign ifm_ext  = {{8{ifm_byte[7]}}, ifm_byte};
  assign wgt_ext  = {{8{wgt_byte[7]}}, wgt_byte};
  assign prod     = ifm_ext * wgt_ext;
  assign prod_ext = {{16{prod[15]}}, prod};

  logic mac_last, out_last, degenerate;
  assign mac_last   = (widx == k_tot - ONE);
  assign out_last   = (mc == m_tot - ONE) && (yc == AW'(ce) - ONE) && (xc == AW'(coc) - ONE);
  assign degenerate = (p == 4'd0) || (t == 4'd0) || (q == 4'd0) || (r == 4'd0) ||
                      (e == 8'd0) || (STRIDE == 4'd0) || (FILT_ROW == 4'd0) ||
                      (FILT_COL == 4'd0) || (OFMAP_COL == 8'd0);

  // Control FSM, counters, accumulator and the registered done flag.
  // NOTE: every state register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
      skip  <= 1'b0;
      cp <= '0; ct <= '0; cq <= '0; cr <= '0; cs <= '0; cfr <= '0; cfc <= '0;
      ce <= '0; cic <= '0; coc <= '0;
      mc <= '0; yc <= '0; xc <= '0; oi <= '0;
      cc <= '0; frc <= '0; fcc <= '0; widx <= '0;
      acc <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // A start in DONE relaunches directly, same timing as from IDLE.
          if (start) begin
            cp <= p; ct <= t; cq <= q; cr <= r; cs <= STRIDE;
            cfr <= FILT_ROW; cfc <= FILT_COL;
            ce <= e; cic <= IFMAP_COL; coc <= OFMAP_COL;
            skip  <= degenerate;
            mc <= '0; yc <= '0; xc <= '0; oi <= '0;
            done  <= 1'b0;
            state <= BIAS;
          end
        end
        BIAS: begin
          if (skip) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cc <= '0; frc <= '0; fcc <= '0; widx <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          // First MAC cycle loads the bias; later ones add the previous product.
          acc <= (widx == '0) ? bias_word : acc + prod_ext;
          widx <= widx + ONE;
          if (fcc == AW'(cfc) - ONE) begin
            fcc <= '0;
            if (frc == AW'(cfr) - ONE) begin
              frc <= '0;
              cc  <= cc + ONE;
            end else begin
              frc <= frc + ONE;
            end
          end else begin
            fcc <= fcc + ONE;
          end
          if (mac_last) state <= DRAIN;
        end
        DRAIN: begin
          acc   <= acc + prod_ext;
          state <= WRITE;
        end
        WRITE: begin
          oi <= oi + ONE;
          if (out_last) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            if (xc == AW'(coc) - ONE) begin
              xc <= '0;
              if (yc == AW'(ce) - ONE) begin
                yc <= '0;
                mc <= mc + ONE;
              end else begin
                yc <= yc + ONE;
              end
            end else begin
              xc <= xc + ONE;
            end
            state <= BIAS;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_one_pass_top.sv
// Directed bench for one_pass_top: hand-computed results, cycle counts,
// untouched GLB regions, reset abort and start protocol.

module tb_one_pass_top;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] p = '0, t = '0, q = '0, r = '0;
  logic [7:0] e = '0;
  logic [3:0] stride = '0, filt_row = '0, filt_col = '0;
  logic [7:0] ifmap_col = '0, ofmap_col = '0;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] img [1024];

  always #5 clk = ~clk;

  one_pass_top dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .p         (p),
    .t         (t),
    .q         (q),
    .r         (r),
    .e         (e),
    .STRIDE    (stride),
    .FILT_ROW  (filt_row),
    .FILT_COL  (filt_col),
    .IFMAP_COL (ifmap_col),
    .OFMAP_COL (ofmap_col),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cfg(input int ip, it, iq, ir, ie, is, ifr, ifc, iic, ioc);
    p = 4'(ip); t = 4'(it); q = 4'(iq); r = 4'(ir); e = 8'(ie);
    stride = 4'(is); filt_row = 4'(ifr); filt_col = 4'(ifc);
    ifmap_col = 8'(iic); ofmap_col = 8'(ioc);
  endtask

  task automatic fill(input logic [7:0] bg);
    for (int a = 0; a < 1024; a++) img[a] = bg;
  endtask

  task automatic load();
    for (int a = 0; a < 1024; a++) dut.glb.mem[a] = img[a];
  endtask

  function automatic logic [31:0] rd32(input int a);
    return {dut.glb.mem[a+3], dut.glb.mem[a+2], dut.glb.mem[a+1], dut.glb.mem[a]};
  endfunction

  function automatic int diffs(input int lo, input int hi);
    int n = 0;
    for (int a = lo; a < hi; a++) if (dut.glb.mem[a] !== img[a]) n++;
    return n;
  endfunction

  // Reference for the stride-2 geometry: C=4, H=5, IFMAP_COL=5, 3x3, F0=100, B0=244.
  function automatic logic [31:0] model_s2(input int m, input int y, input int x);
    int acc;
    int iv, wv;
    acc = int'({img[244+4*m+3], img[244+4*m+2], img[244+4*m+1], img[244+4*m]});
    for (int c = 0; c < 4; c++)
      for (int fr = 0; fr < 3; fr++)
        for (int fc = 0; fc < 3; fc++) begin
          iv = int'($signed(img[c*25 + (y*2+fr)*5 + x*2 + fc]));
          wv = int'($signed(img[100 + ((m*4 + c)*3 + fr)*3 + fc]));
          acc = acc + iv * wv;
        end
    return acc;
  endfunction

  task automatic start_pulse();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Launch a pass and count cycles from the start cycle until done reads 1.
  // pulse_at > 0 re-pulses start in that cycle; cycles stays -1 on timeout.
  task automatic run_pass(input int pulse_at, output int cycles);
    cycles = -1;
    start_pulse();
    for (int n = 1; n <= 2000; n++) begin
      if (n == 1) check("done_low_after_start", {31'b0, done}, 32'd0);
      if (done === 1'b1) begin
        cycles = n;
        break;
      end
      start = (n == pulse_at);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic setup_minimal();
    cfg(1, 1, 1, 1, 1, 1, 1, 1, 4, 4);
    fill(8'h5A);
    img[0] = 8'd1; img[1] = 8'd2; img[2] = 8'd3; img[3] = 8'd4;
    img[4] = 8'd3;
    img[5] = 8'd10; img[6] = 8'd0; img[7] = 8'd0; img[8] = 8'd0;
    load();
  endtask

  task automatic check_minimal(input string tag);
    check({tag, "_w0"}, rd32(9),  32'd13);
    check({tag, "_w1"}, rd32(13), 32'd16);
    check({tag, "_w2"}, rd32(17), 32'd19);
    check({tag, "_w3"}, rd32(21), 32'd22);
  endtask

  task automatic check_stride(input string tag);
    for (int m = 0; m < 4; m++)
      for (int y = 0; y < 2; y++)
        for (int x = 0; x < 2; x++)
          check($sformatf("%s_m%0dy%0dx%0d", tag, m, y, x),
                rd32(260 + 4*(m*4 + y*2 + x)), model_s2(m, y, x));
  endtask

  int cyc;

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_state", 32'(dut.state), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Minimal pass: {1,2,3,4}*3+10 at O0=9, done in cycle 17.
    setup_minimal();
    run_pass(0, cyc);
    check("min_cycles", cyc, 32'd17);
    check_minimal("min");
    check("min_preserved", diffs(0, 9), 32'd0);
    check("min_tail_preserved", diffs(25, 1024), 32'd0);

    // Start pulse during MAC (cycle 6) is ignored; launched from DONE.
    for (int a = 9; a < 25; a++) dut.glb.mem[a] = 8'hAA;
    run_pass(6, cyc);
    check("mac_pulse_cycles", cyc, 32'd17);
    check_minimal("mac_pulse");

    // Plain rerun from DONE gives the same result and timing.
    for (int a = 9; a < 25; a++) dut.glb.mem[a] = 8'h33;
    run_pass(0, cyc);
    check("rerun_cycles", cyc, 32'd17);
    check_minimal("rerun");

    // Signed: nine (-1)*127 products, bias 0 -> -1143.
    cfg(1, 1, 1, 1, 1, 1, 3, 3, 3, 1);
    fill(8'h5A);
    for (int a = 0; a < 9; a++) img[a] = 8'h7F;
    for (int a = 9; a < 18; a++) img[a] = 8'hFF;
    for (int a = 18; a < 22; a++) img[a] = 8'h00;
    load();
    run_pass(0, cyc);
    check("signed_cycles", cyc, 32'd13);
    check("signed_w0", rd32(22), 32'hFFFF_FB89);
    check("signed_preserved", diffs(0, 22), 32'd0);

    // Wrap: 4 * (-128*-128) = 0x10000 onto bias 0x7FFF8000 -> 0x80008000.
    cfg(1, 1, 1, 1, 1, 1, 2, 2, 2, 1);
    fill(8'h5A);
    for (int a = 0; a < 8; a++) img[a] = 8'h80;
    img[8] = 8'h00; img[9] = 8'h80; img[10] = 8'hFF; img[11] = 8'h7F;
    load();
    run_pass(0, cyc);
    check("wrap_cycles", cyc, 32'd8);
    check("wrap_w0", rd32(12), 32'h8000_8000);

    // Stride 2, M=C=4, 3x3, e=2, OFMAP_COL=2: O0=260, 16 words, 16*39+1 cycles.
    cfg(2, 2, 2, 2, 2, 2, 3, 3, 5, 2);
    fill(8'h5A);
    for (int a = 0; a < 260; a++) img[a] = 8'($urandom_range(0, 255));
    load();
    run_pass(0, cyc);
    check("stride_cycles", cyc, 32'd625);
    check_stride("stride");
    check("stride_preserved", diffs(0, 260), 32'd0);

    // Reset mid-pass: abort after 300 cycles, first words stay, rerun is correct.
    for (int a = 260; a < 324; a++) begin
      img[a] = 8'h00;
      dut.glb.mem[a] = 8'h00;
    end
    start_pulse();
    repeat (300) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_state", 32'(dut.state), 32'd0);
    check("abort_kept_w0", rd32(260), model_s2(0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_pass(0, cyc);
    check("after_abort_cycles", cyc, 32'd625);
    check_stride("after_abort");

    // Degenerate (p=0): done two cycles after start, GLB untouched.
    setup_minimal();
    p = 4'd0;
    run_pass(0, cyc);
    check("degen_cycles", cyc, 32'd2);
    check("degen_untouched", diffs(0, 1024), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
